dl_sdram_sequencer: RTL and testbench
=====================================

# dl_sdram_sequencer

Sequences ROM download bytes from `data_io` into the shared SDRAM write ports and on-chip download RAMs. It decouples the `ioctl_wr` strobe from SDRAM acknowledge latency with a small FIFO. It drives the toggle-style `port1_req`/`port2_req` handshakes, remapping graphics addresses for port 2. It also owns the `rom_loaded` flag and the core reset that depends on it, and sits between `data_io`, `sdram` and the arcade core in the top level.

## Interface
Parameters:
- `GFX_BASE`, 25'h10000: first byte address mirrored to port 2; port 2 address = `ioctl_addr - GFX_BASE`.
- `DL_LIMIT`, 25'h28200: `dl_wr` is issued only for addresses below this.
- `FIFO_AW`, 2: FIFO address width; depth = 2^`FIFO_AW` entries of {addr[24:0], data[7:0]}.
- `RESET_HOLD`, 16: `core_reset` stays high for this many cycles after `rom_loaded` rises.

Ports:
- `clk_sys` in 1: sole clock.
- `reset` in 1: asynchronous, active-high.
- `ioctl_downl` in 1: download active.
- `ioctl_wr` in 1: byte strobe; level, edge-detected.
- `ioctl_addr` in 25: byte address.
- `ioctl_dout` in 8: byte data.
- `port1_ack`, `port2_ack` in 1: SDRAM toggle acks (clk_sd domain).
- `user_reset` in 1: OSD reset OR button.
- `port1_req`, `port2_req` out 1: toggle requests.
- `port1_a`, `port2_a` out 23: word addresses.
- `port1_ds`, `port2_ds` out 2: byte selects {a[0], ~a[0]}.
- `port1_d`, `port2_d` out 16: {data, data}.
- `dl_wr` out 1: one-cycle on-chip write pulse.
- `dl_addr` out 18, `dl_data` out 8: on-chip write address and data.
- `rom_loaded` out 1: image fully committed.
- `core_reset` out 1: reset to the arcade core.
- `overflow` out 1: sticky FIFO overrun.

## Operation
- Push: rising edge of `ioctl_wr` while `ioctl_downl`=1 pushes {addr, dout}. A push while full drops the byte and sets `overflow`. `overflow` clears only on `reset` or a download start.
- `port1_ack`/`port2_ack` pass through 2-flop synchronisers. "Port n done" means synced ack == req.
- FSM states:
  - IDLE: FIFO non-empty and both ports done -> ISSUE.
  - ISSUE: drive address, ds and data from the FIFO head. Toggle `port1_req`. Toggle `port2_req` (subject to Configuration). Pulse `dl_wr` if addr < `DL_LIMIT`. -> WAIT.
  - WAIT: both ports done -> pop and go to IDLE.
  - DRAIN: entered from IDLE or WAIT on a falling edge of `ioctl_downl`. Finish pending entries through ISSUE/WAIT. When FIFO empty and both ports done, set `rom_loaded`=1 and go to IDLE.
- Download start (rising `ioctl_downl`) clears `rom_loaded` and `overflow`.
- Simultaneous push and pop in one cycle is legal; occupancy is unchanged.
- `core_reset` = `user_reset` | ~`rom_loaded` | hold counter nonzero. The hold counter loads `RESET_HOLD` on the `rom_loaded` rise and counts down to 0.
- `reset` asynchronously clears FIFO, FSM (to IDLE), reqs, `dl_wr`, `rom_loaded`, `overflow` and counter. Reset mid-handshake abandons the transfer; sdram is also reset by its PLL lock path.

## Timing
- Reset values: all outputs 0, except `core_reset`=1. Address, ds and data outputs are 0.
- Strobe sampled high in cycle N, FIFO empty, FSM in IDLE:
  - entry visible in cycle N+1;
  - ISSUE in cycle N+2;
  - req toggle and `dl_wr` registered at the end of N+2.
- Address, ds and data are stable from ISSUE until the pop.
- Minimum per-byte time is 3 cycles plus ack latency (ack path includes 2 sync cycles).
- `rom_loaded` rises 1 cycle after DRAIN completes.
- `core_reset` falls `RESET_HOLD` cycles after that, provided `user_reset`=0.

## Configuration
- `DL_GFX_GATE_EN` defined:
  - `port2_req` toggles only for addr >= `GFX_BASE`;
  - port 2 done-check is skipped for entries below `GFX_BASE`.
- Undefined:
  - `port2_req` toggles for every byte, with wrapped address `ioctl_addr - GFX_BASE`;
  - both acks are always awaited.

## Test plan
- Single byte: addr 25'h00005, data 8'hA5, ack returned 4 cycles later.
  - `port1_a`=23'h2, `port1_ds`=2'b10, `port1_d`=16'hA5A5.
  - `dl_wr` pulses once with `dl_addr`=18'h5.
  - Pop after ack.
- Graphics byte: addr 25'h10010 with `DL_GFX_GATE_EN`.
  - `port2_a`=23'h8 and both reqs toggle.
  - Addr 25'h00010: only `port1_req` toggles.
- Burst with acks delayed 20 cycles: 5 strobes with `FIFO_AW`=2 -> 4 accepted, 5th dropped, `overflow`=1.
- Limit: addr 25'h28200 -> reqs toggle, no `dl_wr`. Addr 25'h281FF -> `dl_wr`=1.
- End of download: `ioctl_downl` falls with 2 entries pending.
  - `rom_loaded` rises only after the second ack.
  - `core_reset` falls 16 cycles later.
  - Asserting `user_reset` keeps `core_reset` high.
- Async `reset` during WAIT:
  - all outputs return to reset values immediately;
  - FIFO empty;
  - next strobe handled from IDLE.

Source files
------------

// File: rtl/dl_sdram_sequencer_if.sv
// Download bus bundle: data_io byte stream in; SDRAM toggle ports and on-chip RAM write out.
interface dl_sdram_sequencer_if;
  logic        ioctl_downl;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        port1_req;
  logic        port2_req;
  logic        port1_ack;
  logic        port2_ack;
  logic [22:0] port1_a;
  logic [22:0] port2_a;
  logic [1:0]  port1_ds;
  logic [1:0]  port2_ds;
  logic [15:0] port1_d;
  logic [15:0] port2_d;
  logic        dl_wr;
  logic [17:0] dl_addr;
  logic [7:0]  dl_data;

  modport master (
    input  ioctl_downl, ioctl_wr, ioctl_addr, ioctl_dout, port1_ack, port2_ack,
    output port1_req, port2_req, port1_a, port2_a, port1_ds, port2_ds,
           port1_d, port2_d, dl_wr, dl_addr, dl_data
  );

  modport slave (
    output ioctl_downl, ioctl_wr, ioctl_addr, ioctl_dout, port1_ack, port2_ack,
    input  port1_req, port2_req, port1_a, port2_a, port1_ds, port2_ds,
           port1_d, port2_d, dl_wr, dl_addr, dl_data
  );
endinterface

// File: rtl/dl_sdram_sequencer.sv
// ROM download sequencer: FIFO-buffers data_io bytes into SDRAM ports 1/2 and on-chip RAM.
// Optional macro DL_GFX_GATE_EN: port 2 only serves addresses at or above GFX_BASE.
module dl_sdram_sequencer #(
  parameter logic [24:0] GFX_BASE   = 25'h10000,
  parameter logic [24:0] DL_LIMIT   = 25'h28200,
  parameter int          FIFO_AW    = 2,
  parameter int          RESET_HOLD = 16
) (
  input  logic                        clk_sys,
  input  logic                        reset,
  input  logic                        user_reset,
  dl_sdram_sequencer_if.master        bus,
  output logic                        rom_loaded,
  output logic                        core_reset,
  output logic                        overflow
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CNT_W = $clog2(RESET_HOLD + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN} state_t;
  state_t state, state_nxt;

  logic              wr_prev, downl_prev;
  logic              ack1_s0, ack1_s1, ack2_s0, ack2_s1;
  logic [24:0]       fifo_addr [DEPTH];
  logic [7:0]        fifo_data [DEPTH];
  logic [FIFO_AW:0]  wr_ptr, rd_ptr;
  logic              draining;
  logic [CNT_W-1:0]  hold_cnt;

  logic              push_req, push, pop, full, empty;
  logic              dl_start, dl_end;
  logic              gfx_hit, both_raw, both_wait;
  logic [24:0]       head_addr;
  logic [7:0]        head_data;
  logic [23:0]       gfx_off;
  logic              load_out, issue_en, set_loaded, load_hold;

  assign push_req  = bus.ioctl_wr & ~wr_prev & bus.ioctl_downl;
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                     (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign push      = push_req & ~full;
  assign dl_start  = bus.ioctl_downl & ~downl_prev;
  assign dl_end    = ~bus.ioctl_downl & downl_prev;
  assign head_addr = fifo_addr[rd_ptr[FIFO_AW-1:0]];
  assign head_data = fifo_data[rd_ptr[FIFO_AW-1:0]];
  assign gfx_off   = head_addr[23:0] - GFX_BASE[23:0];

`ifdef DL_GFX_GATE_EN
  assign gfx_hit = (head_addr >= GFX_BASE);
`else
  assign gfx_hit = 1'b1;
`endif

  // A port is done once its synchronised ack has caught up with its request toggle
  assign both_raw  = (ack1_s1 == bus.port1_req) & (ack2_s1 == bus.port2_req);
  assign both_wait = (ack1_s1 == bus.port1_req) & ((ack2_s1 == bus.port2_req) | ~gfx_hit);
  assign load_hold = set_loaded & ~rom_loaded & ~dl_start;

  always_ff @(posedge clk_sys) begin
    if (push) begin
      fifo_addr[wr_ptr[FIFO_AW-1:0]] <= bus.ioctl_addr;
      fifo_data[wr_ptr[FIFO_AW-1:0]] <= bus.ioctl_dout;
    end
  end

  always_comb begin
    state_nxt  = state;
    load_out   = 1'b0;
    issue_en   = 1'b0;
    pop        = 1'b0;
    set_loaded = 1'b0;
    case (state)
      S_IDLE: begin
        if (dl_end) begin
          state_nxt = S_DRAIN;
        end else if (!empty && both_raw) begin
          state_nxt = S_ISSUE;
          load_out  = 1'b1;
        end
      end
      S_ISSUE: begin
        issue_en  = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (both_wait) begin
          pop       = 1'b1;
          state_nxt = (draining || dl_end) ? S_DRAIN : S_IDLE;
        end
      end
      S_DRAIN: begin
        if (both_raw) begin
          if (!empty) begin
            state_nxt = S_ISSUE;
            load_out  = 1'b1;
          end else begin
            // A restart during the drain cancels the completion flag
            set_loaded = draining;
            state_nxt  = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      wr_prev    <= 1'b0;
      downl_prev <= 1'b0;
      ack1_s0    <= 1'b0;
      ack1_s1    <= 1'b0;
      ack2_s0    <= 1'b0;
      ack2_s1    <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      draining   <= 1'b0;
      overflow   <= 1'b0;
      rom_loaded <= 1'b0;
      hold_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      wr_prev    <= bus.ioctl_wr;
      downl_prev <= bus.ioctl_downl;
      ack1_s0    <= bus.port1_ack;
      ack1_s1    <= ack1_s0;
      ack2_s0    <= bus.port2_ack;
      ack2_s1    <= ack2_s0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (dl_start) begin
        overflow   <= 1'b0;
        rom_loaded <= 1'b0;
        draining   <= 1'b0;
      end else begin
        if (push_req && full) overflow <= 1'b1;
        if (dl_end)          draining <= 1'b1;
        else if (set_loaded) draining <= 1'b0;
        if (set_loaded)      rom_loaded <= 1'b1;
      end
      if (load_hold)           hold_cnt <= CNT_W'(RESET_HOLD);
      else if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
    end
  end

  // Bus outputs: address/data latched entering ISSUE, request toggles at the end of ISSUE
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      bus.port1_req <= 1'b0;
      bus.port2_req <= 1'b0;
      bus.port1_a   <= '0;
      bus.port2_a   <= '0;
      bus.port1_ds  <= '0;
      bus.port2_ds  <= '0;
      bus.port1_d   <= '0;
      bus.port2_d   <= '0;
      bus.dl_wr     <= 1'b0;
      bus.dl_addr   <= '0;
      bus.dl_data   <= '0;
    end else begin
      bus.dl_wr <= 1'b0;
      if (load_out) begin
        bus.port1_a  <= head_addr[23:1];
        bus.port1_ds <= {head_addr[0], ~head_addr[0]};
        bus.port1_d  <= {head_data, head_data};
        bus.port2_a  <= gfx_off[23:1];
        bus.port2_ds <= {gfx_off[0], ~gfx_off[0]};
        bus.port2_d  <= {head_data, head_data};
        bus.dl_addr  <= head_addr[17:0];
        bus.dl_data  <= head_data;
      end
      if (issue_en) begin
        bus.port1_req <= ~bus.port1_req;
        if (gfx_hit) bus.port2_req <= ~bus.port2_req;
        bus.dl_wr <= (head_addr < DL_LIMIT);
      end
    end
  end

  assign core_reset = user_reset | ~rom_loaded | (hold_cnt != '0);
endmodule

// File: tb/tb_dl_sdram_sequencer.sv
// Directed bench for dl_sdram_sequencer: toggle-ack SDRAM model plus per-scenario inline checks.
module tb_dl_sdram_sequencer;
  logic clk_sys    = 1'b0;
  logic reset      = 1'b0;
  logic user_reset = 1'b0;
  logic rom_loaded, core_reset, overflow;

  int n_chk  = 0;
  int n_fail = 0;
  int ack_dly = 4;
  logic [17:0] dl_log[$];

  dl_sdram_sequencer_if bus();

  dl_sdram_sequencer dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .user_reset(user_reset),
    .bus       (bus),
    .rom_loaded(rom_loaded),
    .core_reset(core_reset),
    .overflow  (overflow)
  );

  always #5 clk_sys = ~clk_sys;

  // SDRAM side: each port answers a request toggle ack_dly cycles after seeing it
  logic p1_seen, p2_seen;
  int   p1_cnt, p2_cnt;
  always @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      bus.port1_ack <= 1'b0; p1_seen <= 1'b0; p1_cnt <= 0;
    end else if (bus.port1_req != p1_seen) begin
      p1_seen <= bus.port1_req; p1_cnt <= ack_dly;
    end else if (p1_cnt == 1) begin
      bus.port1_ack <= p1_seen; p1_cnt <= 0;
    end else if (p1_cnt > 1) begin
      p1_cnt <= p1_cnt - 1;
    end
  end
  always @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      bus.port2_ack <= 1'b0; p2_seen <= 1'b0; p2_cnt <= 0;
    end else if (bus.port2_req != p2_seen) begin
      p2_seen <= bus.port2_req; p2_cnt <= ack_dly;
    end else if (p2_cnt == 1) begin
      bus.port2_ack <= p2_seen; p2_cnt <= 0;
    end else if (p2_cnt > 1) begin
      p2_cnt <= p2_cnt - 1;
    end
  end

  always @(negedge clk_sys) if (bus.dl_wr) dl_log.push_back(bus.dl_addr);

  task automatic strobe(input logic [24:0] a, input logic [7:0] d);
    @(negedge clk_sys);
    bus.ioctl_addr = a; bus.ioctl_dout = d; bus.ioctl_wr = 1'b1;
    @(negedge clk_sys);
    bus.ioctl_wr = 1'b0;
  endtask

  task automatic settle();
    int t = 0;
    while ((bus.port1_ack !== bus.port1_req || bus.port2_ack !== bus.port2_req) && t < 400) begin
      @(negedge clk_sys); t++;
    end
    n_chk++;
    if (t >= 400) begin
      n_fail++;
      $display("FAIL settle_timeout: ack1=%b req1=%b ack2=%b req2=%b, required acks equal reqs",
               bus.port1_ack, bus.port1_req, bus.port2_ack, bus.port2_req);
    end
    repeat (5) @(negedge clk_sys);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk_sys);
    n_chk++; if (bus.port1_req !== 1'b0) begin n_fail++; $display("FAIL rst_req1: got %b need 0", bus.port1_req); end
    n_chk++; if (bus.port2_req !== 1'b0) begin n_fail++; $display("FAIL rst_req2: got %b need 0", bus.port2_req); end
    n_chk++; if (bus.port1_a !== 23'h0) begin n_fail++; $display("FAIL rst_p1_a: got %h need 0", bus.port1_a); end
    n_chk++; if (bus.port2_ds !== 2'b00) begin n_fail++; $display("FAIL rst_p2_ds: got %b need 00", bus.port2_ds); end
    n_chk++; if (bus.port1_d !== 16'h0) begin n_fail++; $display("FAIL rst_p1_d: got %h need 0", bus.port1_d); end
    n_chk++; if (bus.dl_wr !== 1'b0) begin n_fail++; $display("FAIL rst_dl_wr: got %b need 0", bus.dl_wr); end
    n_chk++; if (bus.dl_addr !== 18'h0) begin n_fail++; $display("FAIL rst_dl_addr: got %h need 0", bus.dl_addr); end
    n_chk++; if (rom_loaded !== 1'b0) begin n_fail++; $display("FAIL rst_rom_loaded: got %b need 0", rom_loaded); end
    n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow: got %b need 0", overflow); end
    n_chk++; if (core_reset !== 1'b1) begin n_fail++; $display("FAIL rst_core_reset: got %b need 1", core_reset); end
  endtask

  task automatic test_single();
    logic r1, r2, e2;
    settle(); dl_log.delete();
    r1 = bus.port1_req; r2 = bus.port2_req;
`ifdef DL_GFX_GATE_EN
    e2 = r2;
`else
    e2 = ~r2;
`endif
    strobe(25'h00005, 8'hA5);
    @(negedge clk_sys);
    n_chk++; if (bus.port1_req !== r1) begin n_fail++; $display("FAIL single_early_req: got %b need %b", bus.port1_req, r1); end
    n_chk++; if (bus.port1_a !== 23'h2) begin n_fail++; $display("FAIL single_p1_a: got %h need 2", bus.port1_a); end
    n_chk++; if (bus.port1_ds !== 2'b10) begin n_fail++; $display("FAIL single_p1_ds: got %b need 10", bus.port1_ds); end
    n_chk++; if (bus.port1_d !== 16'hA5A5) begin n_fail++; $display("FAIL single_p1_d: got %h need a5a5", bus.port1_d); end
    @(negedge clk_sys);
    n_chk++; if (bus.port1_req !== ~r1) begin n_fail++; $display("FAIL single_req1: got %b need %b", bus.port1_req, ~r1); end
    n_chk++; if (bus.port2_req !== e2) begin n_fail++; $display("FAIL single_req2: got %b need %b", bus.port2_req, e2); end
    n_chk++; if (bus.dl_wr !== 1'b1) begin n_fail++; $display("FAIL single_dl_wr: got %b need 1", bus.dl_wr); end
    n_chk++; if (bus.dl_addr !== 18'h5) begin n_fail++; $display("FAIL single_dl_addr: got %h need 5", bus.dl_addr); end
    n_chk++; if (bus.dl_data !== 8'hA5) begin n_fail++; $display("FAIL single_dl_data: got %h need a5", bus.dl_data); end
    n_chk++; if (bus.port2_a !== 23'h7F8002) begin n_fail++; $display("FAIL single_p2_a: got %h need 7f8002", bus.port2_a); end
    @(negedge clk_sys);
    n_chk++; if (bus.dl_wr !== 1'b0) begin n_fail++; $display("FAIL single_dl_wr_pulse: got %b need 0", bus.dl_wr); end
    repeat (3) @(negedge clk_sys);
    n_chk++; if (bus.port1_a !== 23'h2) begin n_fail++; $display("FAIL single_p1_a_stable: got %h need 2", bus.port1_a); end
    settle(); repeat (10) @(negedge clk_sys);
    n_chk++; if (dl_log.size() != 1) begin n_fail++; $display("FAIL single_pop: got %0d dl_wr pulses need 1", dl_log.size()); end
  endtask

  task automatic test_gfx();
    logic r1, r2, e2;
    settle();
    r1 = bus.port1_req; r2 = bus.port2_req;
    strobe(25'h10010, 8'h3C);
    @(negedge clk_sys);
    n_chk++; if (bus.port2_a !== 23'h8) begin n_fail++; $display("FAIL gfx_p2_a: got %h need 8", bus.port2_a); end
    n_chk++; if (bus.port2_ds !== 2'b01) begin n_fail++; $display("FAIL gfx_p2_ds: got %b need 01", bus.port2_ds); end
    n_chk++; if (bus.port1_a !== 23'h8008) begin n_fail++; $display("FAIL gfx_p1_a: got %h need 8008", bus.port1_a); end
    @(negedge clk_sys);
    n_chk++; if (bus.port1_req !== ~r1) begin n_fail++; $display("FAIL gfx_req1: got %b need %b", bus.port1_req, ~r1); end
    n_chk++; if (bus.port2_req !== ~r2) begin n_fail++; $display("FAIL gfx_req2: got %b need %b", bus.port2_req, ~r2); end
    settle();
    r1 = bus.port1_req; r2 = bus.port2_req;
`ifdef DL_GFX_GATE_EN
    e2 = r2;
`else
    e2 = ~r2;
`endif
    strobe(25'h00010, 8'h11);
    repeat (2) @(negedge clk_sys);
    n_chk++; if (bus.port1_req !== ~r1) begin n_fail++; $display("FAIL low_req1: got %b need %b", bus.port1_req, ~r1); end
    n_chk++; if (bus.port2_req !== e2) begin n_fail++; $display("FAIL low_req2: got %b need %b", bus.port2_req, e2); end
    n_chk++; if (bus.port1_a !== 23'h8) begin n_fail++; $display("FAIL low_p1_a: got %h need 8", bus.port1_a); end
    settle();
  endtask

  task automatic test_limit();
    logic r1, r2;
    settle();
    r1 = bus.port1_req; r2 = bus.port2_req;
    strobe(25'h28200, 8'h77);
    repeat (2) @(negedge clk_sys);
    n_chk++; if (bus.dl_wr !== 1'b0) begin n_fail++; $display("FAIL limit_dl_wr: got %b need 0", bus.dl_wr); end
    n_chk++; if (bus.port1_req !== ~r1) begin n_fail++; $display("FAIL limit_req1: got %b need %b", bus.port1_req, ~r1); end
    n_chk++; if (bus.port2_req !== ~r2) begin n_fail++; $display("FAIL limit_req2: got %b need %b", bus.port2_req, ~r2); end
    n_chk++; if (bus.port1_a !== 23'h14100) begin n_fail++; $display("FAIL limit_p1_a: got %h need 14100", bus.port1_a); end
    settle();
    strobe(25'h281FF, 8'h88);
    repeat (2) @(negedge clk_sys);
    n_chk++; if (bus.dl_wr !== 1'b1) begin n_fail++; $display("FAIL below_dl_wr: got %b need 1", bus.dl_wr); end
    n_chk++; if (bus.dl_addr !== 18'h281FF) begin n_fail++; $display("FAIL below_dl_addr: got %h need 281ff", bus.dl_addr); end
    settle();
  endtask

  task automatic test_overflow();
    logic [24:0] a;
    logic [17:0] e;
    ack_dly = 20;
    settle(); dl_log.delete();
    for (int i = 0; i < 5; i++) begin
      a = 25'h100 + 25'(i);
      strobe(a, 8'h10 + 8'(i));
      if (i == 3) begin
        n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b need 0", overflow); end
      end
    end
    @(negedge clk_sys);
    n_chk++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b need 1", overflow); end
    repeat (250) @(negedge clk_sys);
    settle();
    n_chk++; if (dl_log.size() != 4) begin n_fail++; $display("FAIL ovf_count: got %0d bytes need 4", dl_log.size()); end
    for (int i = 0; i < 4 && i < dl_log.size(); i++) begin
      e = 18'h100 + 18'(i);
      n_chk++; if (dl_log[i] !== e) begin n_fail++; $display("FAIL ovf_order%0d: got %h need %h", i, dl_log[i], e); end
    end
    ack_dly = 4;
  endtask

  task automatic test_end();
    logic a_prev;
    int seen, t, n;
    ack_dly = 6;
    settle(); dl_log.delete();
    strobe(25'h200, 8'h01);
    strobe(25'h201, 8'h02);
    @(negedge clk_sys);
    bus.ioctl_downl = 1'b0;
    a_prev = bus.port1_ack; seen = 0; t = 0;
    while (seen < 2 && t < 400) begin
      @(negedge clk_sys); t++;
      if (bus.port1_ack !== a_prev) begin
        a_prev = bus.port1_ack; seen++;
        n_chk++; if (rom_loaded !== 1'b0) begin n_fail++; $display("FAIL end_early_loaded%0d: got %b need 0", seen, rom_loaded); end
      end
    end
    n_chk++; if (seen != 2) begin n_fail++; $display("FAIL end_acks: got %0d acks need 2", seen); end
    t = 0;
    while (rom_loaded !== 1'b1 && t < 20) begin @(negedge clk_sys); t++; end
    n_chk++; if (rom_loaded !== 1'b1) begin n_fail++; $display("FAIL end_loaded: got %b need 1", rom_loaded); end
    n_chk++; if (dl_log.size() != 2) begin n_fail++; $display("FAIL end_drained: got %0d bytes need 2", dl_log.size()); end
    n_chk++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL end_ovf_sticky: got %b need 1", overflow); end
    n = 0;
    while (core_reset === 1'b1 && n < 40) begin @(negedge clk_sys); n++; end
    n_chk++; if (n != 16) begin n_fail++; $display("FAIL end_hold: got %0d cycles need 16", n); end
    user_reset = 1'b1; #1;
    n_chk++; if (core_reset !== 1'b1) begin n_fail++; $display("FAIL end_user_reset: got %b need 1", core_reset); end
    @(negedge clk_sys); user_reset = 1'b0; #1;
    n_chk++; if (core_reset !== 1'b0) begin n_fail++; $display("FAIL end_release: got %b need 0", core_reset); end
    @(negedge clk_sys); bus.ioctl_downl = 1'b1;
    @(negedge clk_sys);
    n_chk++; if (rom_loaded !== 1'b0) begin n_fail++; $display("FAIL start_loaded: got %b need 0", rom_loaded); end
    n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL start_ovf: got %b need 0", overflow); end
    n_chk++; if (core_reset !== 1'b1) begin n_fail++; $display("FAIL start_core_reset: got %b need 1", core_reset); end
    ack_dly = 4;
  endtask

  task automatic test_reset_mid();
    logic r1;
    ack_dly = 1000;
    settle();
    r1 = bus.port1_req;
    strobe(25'h300, 8'h33);
    repeat (3) @(negedge clk_sys);
    n_chk++; if (bus.port1_req !== ~r1) begin n_fail++; $display("FAIL mid_req_before: got %b need %b", bus.port1_req, ~r1); end
    #2 reset = 1'b1; #1;
    n_chk++; if (bus.port1_req !== 1'b0) begin n_fail++; $display("FAIL mid_req1: got %b need 0", bus.port1_req); end
    n_chk++; if (bus.port2_req !== 1'b0) begin n_fail++; $display("FAIL mid_req2: got %b need 0", bus.port2_req); end
    n_chk++; if (bus.port1_a !== 23'h0) begin n_fail++; $display("FAIL mid_p1_a: got %h need 0", bus.port1_a); end
    n_chk++; if (bus.dl_addr !== 18'h0) begin n_fail++; $display("FAIL mid_dl_addr: got %h need 0", bus.dl_addr); end
    n_chk++; if (core_reset !== 1'b1) begin n_fail++; $display("FAIL mid_core_reset: got %b need 1", core_reset); end
    @(negedge clk_sys); reset = 1'b0; ack_dly = 4; dl_log.delete();
    repeat (10) @(negedge clk_sys);
    n_chk++; if (dl_log.size() != 0) begin n_fail++; $display("FAIL mid_fifo_empty: got %0d writes need 0", dl_log.size()); end
    n_chk++; if (bus.port1_req !== 1'b0) begin n_fail++; $display("FAIL mid_no_replay: got %b need 0", bus.port1_req); end
    strobe(25'h305, 8'h55);
    @(negedge clk_sys);
    n_chk++; if (bus.port1_a !== 23'h182) begin n_fail++; $display("FAIL post_p1_a: got %h need 182", bus.port1_a); end
    n_chk++; if (bus.port1_ds !== 2'b10) begin n_fail++; $display("FAIL post_p1_ds: got %b need 10", bus.port1_ds); end
    @(negedge clk_sys);
    n_chk++; if (bus.port1_req !== 1'b1) begin n_fail++; $display("FAIL post_req1: got %b need 1", bus.port1_req); end
    n_chk++; if (bus.dl_wr !== 1'b1) begin n_fail++; $display("FAIL post_dl_wr: got %b need 1", bus.dl_wr); end
    n_chk++; if (bus.dl_addr !== 18'h305) begin n_fail++; $display("FAIL post_dl_addr: got %h need 305", bus.dl_addr); end
    settle();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ioctl_downl = 1'b0;
    bus.ioctl_wr    = 1'b0;
    bus.ioctl_addr  = '0;
    bus.ioctl_dout  = '0;
    #3 reset = 1'b1;
    test_reset();
    @(negedge clk_sys); reset = 1'b0; bus.ioctl_downl = 1'b1;
    repeat (3) @(negedge clk_sys);
    test_single();
    test_gfx();
    test_limit();
    test_overflow();
    test_end();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
